// File: rtl/writeback_arbiter.sv
// Round-robin arbiter merging NUM_CH coalescing writeback channels onto one
// valid/ready port; per-channel one-deep holding register, saturating overwrite count.
module writeback_arbiter #(
  parameter int NUM_CH     = 9,
  parameter int DATA_WIDTH = 40,
  parameter int CNT_WIDTH  = 16,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [NUM_CH-1:0]            in_valid_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [DATA_WIDTH-1:0]        out_data_o,
  output logic [CH_W-1:0]              out_ch_o,
  output logic [CNT_WIDTH-1:0]         ovr_cnt_o,
  input  logic                         ovr_clr_i,
  output logic                         idle_o
);

  localparam int PW = $clog2(NUM_CH + 1);
  localparam int SW = ((CNT_WIDTH > PW) ? CNT_WIDTH : PW) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [NUM_CH-1:0]     pend_q, pend_d;
  logic [DATA_WIDTH-1:0] hold_q [NUM_CH];
  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [CH_W-1:0]       out_ch_q;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  load_en, gnt_any, do_grant;
  logic [CH_W-1:0]       gnt_idx;
  logic [CH_W:0]         idx_w;
  logic [NUM_CH-1:0]     gnt_vec, ovr_vec;
  logic [PW-1:0]         ovr_num;
  logic [SW-1:0]         cnt_sum;

  assign load_en  = ~out_valid_q | out_ready_i;
  assign do_grant = load_en & gnt_any;

  // First pending channel at or above rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx_w   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx_w = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
      if (idx_w >= (CH_W+1)'(NUM_CH)) idx_w = idx_w - (CH_W+1)'(NUM_CH);
      if (!gnt_any && pend_q[idx_w[CH_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx_w[CH_W-1:0];
      end
    end
  end

  // A write to the channel being granted this edge refills it; it is not an overwrite.
  always_comb begin
    gnt_vec = '0;
    ovr_num = '0;
    for (int k = 0; k < NUM_CH; k++) gnt_vec[k] = do_grant && (gnt_idx == CH_W'(k));
    ovr_vec = in_valid_i & pend_q & ~gnt_vec;
    for (int k = 0; k < NUM_CH; k++) ovr_num = ovr_num + PW'(ovr_vec[k]);
  end

  always_comb begin
    pend_d  = in_valid_i | (pend_q & ~gnt_vec);
    cnt_sum = SW'(cnt_q) + SW'(ovr_num);
    if (ovr_clr_i)                  cnt_d = '0;
    else if (cnt_sum > SW'(CNT_MAX)) cnt_d = CNT_MAX;
    else                            cnt_d = cnt_sum[CNT_WIDTH-1:0];
    rr_ptr_d = rr_ptr_q;
    if (do_grant) rr_ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pend_q      <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      cnt_q       <= '0;
      for (int k = 0; k < NUM_CH; k++) hold_q[k] <= '0;
    end else begin
      pend_q   <= pend_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      for (int k = 0; k < NUM_CH; k++)
        if (in_valid_i[k]) hold_q[k] <= in_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      if (load_en) begin
        out_valid_q <= gnt_any;
        if (gnt_any) begin
          out_data_q <= hold_q[gnt_idx];
          out_ch_q   <= gnt_idx;
        end
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_ch_o    = out_ch_q;
  assign ovr_cnt_o   = cnt_q;
  assign idle_o      = ~|pend_q & ~out_valid_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter (NUM_CH=9, DATA_WIDTH=40, CNT_WIDTH=4).
module tb_writeback_arbiter;
  localparam int NC = 9;
  localparam int DW = 40;
  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic [NC-1:0]    in_valid;
  logic [NC*DW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [3:0]       out_ch;
  logic [CW-1:0]    ovr_cnt;
  logic             ovr_clr;
  logic             idle;

  int n_tests = 0;
  int n_fail  = 0;

  writeback_arbiter #(.NUM_CH(NC), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rstn_i(rstn), .in_valid_i(in_valid), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_ch_o(out_ch), .ovr_cnt_o(ovr_cnt), .ovr_clr_i(ovr_clr), .idle_o(idle)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int k, input logic [DW-1:0] d);
    in_valid[k] = 1'b1;
    in_data[k*DW +: DW] = d;
  endtask

  task automatic do_reset();
    in_valid = '0; in_data = '0; out_ready = 1'b0; ovr_clr = 1'b0;
    #2 rstn = 1'b0;
    #10 rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    in_valid = '0; in_data = '0; out_ready = 1'b0; ovr_clr = 1'b0;
    rstn = 1'b0;
    #12;
    n_tests++;
    if ({out_valid, out_data, out_ch, ovr_cnt, idle} !== {1'b0, 40'h0, 4'h0, 4'h0, 1'b1}) begin
      $display("FAIL reset_values: got v=%b d=%h ch=%0d cnt=%0d idle=%b, want 0/0/0/0/1",
               out_valid, out_data, out_ch, ovr_cnt, idle);
      n_fail++;
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    wr(3, 40'hAB_CDEF_0123);
    tick();
    in_valid = '0;
    n_tests++;
    if (out_valid !== 1'b0 || idle !== 1'b0) begin
      $display("FAIL single_latency: after E0 v=%b idle=%b, want v=0 idle=0", out_valid, idle);
      n_fail++;
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_ch !== 4'd3 || out_data !== 40'hAB_CDEF_0123) begin
      $display("FAIL single_out: v=%b ch=%0d d=%h, want 1/3/abcdef0123", out_valid, out_ch, out_data);
      n_fail++;
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || idle !== 1'b1) begin
      $display("FAIL single_done: v=%b idle=%b, want v=0 idle=1", out_valid, idle);
      n_fail++;
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < NC; k++) wr(k, DW'(k + 16 * b));
      tick();
      in_valid = '0;
      for (int g = 0; g < NC; g++) begin
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_ch !== 4'(g) || out_data !== DW'(g + 16 * b)) begin
          $display("FAIL rr_burst%0d_grant%0d: v=%b ch=%0d d=%h, want 1/%0d/%h",
                   b, g, out_valid, out_ch, out_data, g, g + 16 * b);
          n_fail++;
        end
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b0 || idle !== 1'b1) begin
        $display("FAIL rr_burst%0d_end: v=%b idle=%b, want 0/1", b, out_valid, idle);
        n_fail++;
      end
    end
  endtask

  task automatic test_coalesce();
    do_reset();
    wr(5, 40'h10); tick();
    wr(5, 40'h11); tick();   // 0x10 granted into output, 0x11 refills ch5
    wr(5, 40'h12); tick();   // stalled: 0x11 overwritten
    in_valid = '0;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 40'h10 || out_ch !== 4'd5 || ovr_cnt !== 4'd1) begin
      $display("FAIL coalesce_stall: v=%b d=%h ch=%0d cnt=%0d, want 1/10/5/1",
               out_valid, out_data, out_ch, ovr_cnt);
      n_fail++;
    end
    out_ready = 1'b1;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 40'h12 || out_ch !== 4'd5) begin
      $display("FAIL coalesce_latest: v=%b d=%h ch=%0d, want 1/12/5", out_valid, out_data, out_ch);
      n_fail++;
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || ovr_cnt !== 4'd1) begin
      $display("FAIL coalesce_end: v=%b cnt=%0d, want 0/1", out_valid, ovr_cnt);
      n_fail++;
    end
  endtask

  task automatic test_collision();
    do_reset();
    out_ready = 1'b1;
    wr(2, 40'h7); tick();
    wr(2, 40'h8); tick();
    in_valid = '0;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 40'h7 || out_ch !== 4'd2 || ovr_cnt !== 4'd0) begin
      $display("FAIL collision_old: v=%b d=%h ch=%0d cnt=%0d, want 1/7/2/0",
               out_valid, out_data, out_ch, ovr_cnt);
      n_fail++;
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 40'h8 || out_ch !== 4'd2 || ovr_cnt !== 4'd0) begin
      $display("FAIL collision_new: v=%b d=%h ch=%0d cnt=%0d, want 1/8/2/0",
               out_valid, out_data, out_ch, ovr_cnt);
      n_fail++;
    end
    tick();
    n_tests++;
    if (idle !== 1'b1) begin
      $display("FAIL collision_idle: idle=%b, want 1", idle);
      n_fail++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < NC; k++) wr(k, DW'(k)); tick();
    for (int k = 0; k < NC; k++) wr(k, DW'(k)); tick();  // ch0 granted, 8 overwrites
    n_tests++;
    if (ovr_cnt !== 4'd8) begin
      $display("FAIL sat_first: cnt=%0d, want 8", ovr_cnt);
      n_fail++;
    end
    for (int k = 0; k < NC; k++) wr(k, DW'(k)); tick();  // 9 more -> 17 saturates
    n_tests++;
    if (ovr_cnt !== 4'd15) begin
      $display("FAIL sat_cap: cnt=%0d, want 15", ovr_cnt);
      n_fail++;
    end
    in_valid = '0;
    wr(1, 40'h1); wr(2, 40'h2); wr(3, 40'h3); tick();   // total 20
    n_tests++;
    if (ovr_cnt !== 4'd15) begin
      $display("FAIL sat_hold: cnt=%0d, want 15", ovr_cnt);
      n_fail++;
    end
    in_valid = '0;
    ovr_clr = 1'b1; wr(4, 40'h4); wr(5, 40'h5); tick();
    ovr_clr = 1'b0; in_valid = '0;
    n_tests++;
    if (ovr_cnt !== 4'd0) begin
      $display("FAIL sat_clear: cnt=%0d, want 0", ovr_cnt);
      n_fail++;
    end
    wr(6, 40'h6); tick();
    in_valid = '0;
    n_tests++;
    if (ovr_cnt !== 4'd1 || out_ch !== 4'd0 || out_valid !== 1'b1) begin
      $display("FAIL sat_after_clear: cnt=%0d ch=%0d v=%b, want 1/0/1", ovr_cnt, out_ch, out_valid);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 1; k <= 5; k++) wr(k, DW'(k)); tick();
    in_valid = '0; tick();          // ch1 in output, ch2..5 pending
    wr(3, 40'h33); tick();          // one overwrite
    in_valid = '0;
    n_tests++;
    if (out_valid !== 1'b1 || out_ch !== 4'd1 || ovr_cnt !== 4'd1 || idle !== 1'b0) begin
      $display("FAIL mid_setup: v=%b ch=%0d cnt=%0d idle=%b, want 1/1/1/0",
               out_valid, out_ch, ovr_cnt, idle);
      n_fail++;
    end
    #2 rstn = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, out_data, out_ch, ovr_cnt, idle} !== {1'b0, 40'h0, 4'h0, 4'h0, 1'b1}) begin
      $display("FAIL mid_async: v=%b d=%h ch=%0d cnt=%0d idle=%b, want 0/0/0/0/1",
               out_valid, out_data, out_ch, ovr_cnt, idle);
      n_fail++;
    end
    #10 rstn = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b0 || idle !== 1'b1) begin
        $display("FAIL mid_no_replay_c%0d: v=%b idle=%b, want 0/1", c, out_valid, idle);
        n_fail++;
      end
    end
  endtask

  initial begin
    rstn = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_coalesce();
    test_collision();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
